// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: PLL retune sequencer (reconfig writes, lock supervision, reset retries); define PLL_CFG_FRAC_EN to add the K write
module pll_reconfig_seq #(
  parameter int LOCK_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int RST_CYCLES     = 64,
  parameter int MAX_RETRY      = 3
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_c0,
  input  logic [31:0] cfg_k,
  input  logic        locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  output logic        pll_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int LW = $clog2(LOCK_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int YW = $clog2(MAX_RETRY) + 1;
  localparam logic [LW-1:0] LOCK_N  = LW'(LOCK_CYCLES);
  localparam logic [TW-1:0] TMO_N   = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RST_N   = RW'(RST_CYCLES);
  localparam logic [YW-1:0] RETRY_N = YW'(MAX_RETRY);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_PRST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_FAIL = 3'd5;
`ifdef PLL_CFG_FRAC_EN
  localparam logic [2:0] LAST = 3'd5;
  logic [31:0] k_q, k_d, k_w;
  assign k_w = k_q;
`else
  localparam logic [2:0] LAST = 3'd4;
  logic [31:0] k_w;
  logic        unused_k;
  assign k_w = '0;
  assign unused_k = ^cfg_k;
`endif
  logic [2:0]    state_q, state_d, idx_q, idx_d;
  logic [LW-1:0] lock_q, lock_d, lock_nx;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;
  logic [YW-1:0] retry_q, retry_d;
  logic [1:0]    sync_q;
  logic [17:0]   m_q, m_d, n_q, n_d, c0_q, c0_d;
  logic          err_q, err_d, locked_s, retry_ok, wr;
  assign locked_s = sync_q[1];
  assign lock_nx  = locked_s ? lock_q + 1'b1 : '0;
  assign tmo_inc  = tmo_q + 1'b1;
  assign rcnt_inc = rcnt_q + 1'b1;
  assign retry_ok = retry_q < RETRY_N;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lock_d  = lock_q;
    tmo_d   = tmo_q;
    rcnt_d  = rcnt_q;
    retry_d = retry_q;
    err_d   = err_q;
    m_d     = m_q;
    n_d     = n_q;
    c0_d    = c0_q;
`ifdef PLL_CFG_FRAC_EN
    k_d     = k_q;
`endif
    case (state_q)
      S_IDLE: if (cfg_req) begin
        state_d = S_WRITE;
        idx_d   = '0;
        err_d   = 1'b0;
        retry_d = '0;
        m_d     = cfg_m;
        n_d     = cfg_n;
        c0_d    = cfg_c0;
`ifdef PLL_CFG_FRAC_EN
        k_d     = cfg_k;
`endif
      end
      S_WRITE: if (idx_q == LAST) begin
        // the start write stalls for the whole reconfiguration, so it shares the lock timeout
        tmo_d = tmo_inc;
        if (tmo_inc == TMO_N) begin
          state_d = retry_ok ? S_PRST : S_FAIL;
          rcnt_d  = '0;
          retry_d = retry_ok ? retry_q + 1'b1 : retry_q;
          err_d   = !retry_ok;
        end else if (!mgmt_waitrequest) begin
          state_d = S_WAIT;
          lock_d  = '0;
        end
      end else if (!mgmt_waitrequest) begin
        idx_d = idx_q + 3'd1;
        tmo_d = '0;
      end
      S_WAIT: begin
        lock_d = lock_nx;
        tmo_d  = tmo_inc;
        if (lock_nx == LOCK_N) state_d = S_DONE;
        else if (tmo_inc == TMO_N) begin
          state_d = retry_ok ? S_PRST : S_FAIL;
          rcnt_d  = '0;
          retry_d = retry_ok ? retry_q + 1'b1 : retry_q;
          err_d   = !retry_ok;
        end
      end
      S_PRST: begin
        rcnt_d = rcnt_inc;
        if (rcnt_inc == RST_N) begin
          state_d = S_WAIT;
          tmo_d   = '0;
          lock_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    wr             = state_q == S_WRITE;
    mgmt_write     = wr;
    mgmt_address   = !wr ? 6'd0 : idx_q == LAST ? 6'd2 : idx_q == 3'd1 ? 6'd4 :
                     idx_q == 3'd2 ? 6'd3 : idx_q == 3'd3 ? 6'd5 : idx_q == 3'd4 ? 6'd7 : 6'd0;
    mgmt_writedata = !wr || idx_q == LAST ? 32'd0 : idx_q == 3'd1 ? {14'b0, m_q} :
                     idx_q == 3'd2 ? {14'b0, n_q} : idx_q == 3'd3 ? {14'b0, c0_q} :
                     idx_q == 3'd4 ? k_w : 32'd0;
    pll_rst        = state_q == S_PRST;
    busy           = wr || state_q == S_WAIT || state_q == S_PRST;
    done           = state_q == S_DONE || state_q == S_FAIL;
    error          = err_q;
  end
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lock_q  <= '0;
      tmo_q   <= '0;
      rcnt_q  <= '0;
      retry_q <= '0;
      sync_q  <= '0;
      err_q   <= 1'b0;
      m_q     <= '0;
      n_q     <= '0;
      c0_q    <= '0;
`ifdef PLL_CFG_FRAC_EN
      k_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
      rcnt_q  <= rcnt_d;
      retry_q <= retry_d;
      sync_q  <= {sync_q[0], locked};
      err_q   <= err_d;
      m_q     <= m_d;
      n_q     <= n_d;
      c0_q    <= c0_d;
`ifdef PLL_CFG_FRAC_EN
      k_q     <= k_d;
`endif
    end
  end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq: directed bench for pll_reconfig_seq with short lock/timeout/reset parameters
module tb_pll_reconfig_seq;
  localparam int LC = 4, TC = 64, RC = 8, MR = 2;
`ifdef PLL_CFG_FRAC_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif
  logic        refclk = 1'b0;
  logic        rst, cfg_req, locked, mgmt_write, mgmt_waitrequest, pll_rst, busy, done, error;
  logic [17:0] cfg_m, cfg_n, cfg_c0;
  logic [31:0] cfg_k, mgmt_writedata;
  logic [5:0]  mgmt_address;
  logic [5:0]  ea [NW];
  logic [31:0] ed [NW];
  int total = 0, bad = 0;

  pll_reconfig_seq #(.LOCK_CYCLES(LC), .TIMEOUT_CYCLES(TC), .RST_CYCLES(RC), .MAX_RETRY(MR)) dut (
    .refclk(refclk), .rst(rst), .cfg_req(cfg_req), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_c0(cfg_c0),
    .cfg_k(cfg_k), .locked(locked), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest), .pll_rst(pll_rst),
    .busy(busy), .done(done), .error(error));

  always #5 refclk = ~refclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  task automatic request(input logic [17:0] m, input logic [17:0] n, input logic [17:0] c, input logic [31:0] k);
    cfg_m = m; cfg_n = n; cfg_c0 = c; cfg_k = k; cfg_req = 1'b1;
    ea[0] = 6'd0; ed[0] = 32'd0;
    ea[1] = 6'd4; ed[1] = {14'b0, m};
    ea[2] = 6'd3; ed[2] = {14'b0, n};
    ea[3] = 6'd5; ed[3] = {14'b0, c};
`ifdef PLL_CFG_FRAC_EN
    ea[4] = 6'd7; ed[4] = k;
`endif
    ea[NW-1] = 6'd2; ed[NW-1] = 32'd0;
    tick;
    cfg_req = 1'b0;
  endtask

  task automatic run_writes(input int sidx, input int sn);
    for (int i = 0; i < NW; i++)
      for (int s = 0; s <= (i == sidx ? sn : 0); s++) begin
        mgmt_waitrequest = (i == sidx) && (s < sn);
        total++;
        if (mgmt_write !== 1'b1 || mgmt_address !== ea[i] || mgmt_writedata !== ed[i]) begin
          bad++;
          $display("FAIL write%0d.%0d: got wr=%b addr=%0d data=%h want wr=1 addr=%0d data=%h",
                   i, s, mgmt_write, mgmt_address, mgmt_writedata, ea[i], ed[i]);
        end
        tick;
      end
    mgmt_waitrequest = 1'b0;
    total++;
    if (mgmt_write !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL after_writes: got wr=%b busy=%b want wr=0 busy=1", mgmt_write, busy);
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        n = i;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({mgmt_write, pll_rst, busy, done, error, mgmt_address, mgmt_writedata} !== 43'd0) begin
      bad++;
      $display("FAIL reset_async: got wr=%b prst=%b busy=%b done=%b err=%b addr=%0d data=%h want all 0",
               mgmt_write, pll_rst, busy, done, error, mgmt_address, mgmt_writedata);
    end
    tick; tick;
    rst = 1'b0;
    tick;
    total++;
    if ({mgmt_write, pll_rst, busy, done, error} !== 5'd0) begin
      bad++;
      $display("FAIL reset_idle: got wr=%b prst=%b busy=%b done=%b err=%b want 0",
               mgmt_write, pll_rst, busy, done, error);
    end
  endtask

  task automatic test_basic;
    int n;
    request(18'h00404, 18'h10000, 18'h00808, 32'h12345678);
    run_writes(-1, 0);
    repeat (4) tick;
    locked = 1'b1;
    wait_done(20, n);
    total++;
    if (n !== 6 || error !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: got delay=%0d err=%b busy=%b want delay=6 err=0 busy=0", n, error, busy);
    end
    locked = 1'b0;
    tick;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_stall;
    int n;
    request(18'h00a0b, 18'h00c0d, 18'h00e0f, 32'h0badf00d);
    run_writes(1, 3);
    locked = 1'b1;
    wait_done(20, n);
    total++;
    if (n !== 6 || error !== 1'b0) begin
      bad++;
      $display("FAIL stall_done: got delay=%0d err=%b want delay=6 err=0", n, error);
    end
    locked = 1'b0;
    tick;
  endtask

  task automatic test_glitch;
    int n;
    logic seen;
    seen = 1'b0;
    request(18'h00101, 18'h00202, 18'h00303, 32'h00000001);
    run_writes(-1, 0);
    locked = 1'b1;
    repeat (3) begin
      seen |= done;
      tick;
    end
    locked = 1'b0;
    seen |= done;
    tick;
    locked = 1'b1;
    wait_done(30, n);
    total++;
    if (seen !== 1'b0 || n !== 6) begin
      bad++;
      $display("FAIL glitch_restart: got early=%b delay=%0d want early=0 delay=6", seen, n);
    end
    locked = 1'b0;
    tick;
  endtask

  task automatic test_retry;
    int n, w;
    request(18'h00404, 18'h10000, 18'h00808, 32'h0);
    run_writes(-1, 0);
    n = -1;
    for (int i = 0; i < 100; i++) begin
      if (pll_rst === 1'b1) begin
        n = i;
        break;
      end
      tick;
    end
    total++;
    if (n !== TC - 1) begin
      bad++;
      $display("FAIL retry_timeout: got %0d want %0d", n, TC - 1);
    end
    w = 0;
    while (pll_rst === 1'b1 && w < 20) begin
      w++;
      tick;
    end
    total++;
    if (w !== RC || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL retry_pulse: got width=%0d busy=%b done=%b want width=%0d busy=1 done=0", w, busy, done, RC);
    end
    locked = 1'b1;
    wait_done(20, n);
    total++;
    if (n !== 6 || error !== 1'b0) begin
      bad++;
      $display("FAIL retry_done: got delay=%0d err=%b want delay=6 err=0", n, error);
    end
    locked = 1'b0;
    tick;
  endtask

  task automatic test_fail;
    int n, pulses, highs;
    logic prev;
    pulses = 0; highs = 0; prev = 1'b0; n = -1;
    request(18'h00111, 18'h00222, 18'h00333, 32'h0);
    run_writes(-1, 0);
    for (int i = 0; i < 400; i++) begin
      if (done === 1'b1) begin
        n = i;
        break;
      end
      if (pll_rst && !prev) pulses++;
      if (pll_rst) highs++;
      prev = pll_rst;
      tick;
    end
    total++;
    if (n !== 3 * TC + 2 * RC - 1 || pulses !== MR || highs !== MR * RC) begin
      bad++;
      $display("FAIL fail_sequence: got at=%0d pulses=%0d highs=%0d want at=%0d pulses=%0d highs=%0d",
               n, pulses, highs, 3 * TC + 2 * RC - 1, MR, MR * RC);
    end
    total++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL fail_flag: got err=%b busy=%b want err=1 busy=0", error, busy);
    end
    repeat (3) tick;
    total++;
    if (error !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL fail_hold: got err=%b done=%b want err=1 done=0", error, done);
    end
    request(18'h00404, 18'h10000, 18'h00808, 32'h0);
    total++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL fail_clear: got err=%b busy=%b want err=0 busy=1", error, busy);
    end
    run_writes(-1, 0);
    locked = 1'b1;
    wait_done(20, n);
    total++;
    if (n !== 6 || error !== 1'b0) begin
      bad++;
      $display("FAIL fail_recover: got delay=%0d err=%b want delay=6 err=0", n, error);
    end
    locked = 1'b0;
    tick;
  endtask

  task automatic test_mid_reset;
    request(18'h00404, 18'h10000, 18'h00808, 32'h0);
    run_writes(-1, 0);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mgmt_write, pll_rst, busy, done, error, mgmt_address, mgmt_writedata} !== 43'd0) begin
      bad++;
      $display("FAIL midrst_async: got wr=%b prst=%b busy=%b done=%b err=%b want all 0",
               mgmt_write, pll_rst, busy, done, error);
    end
    tick;
    rst = 1'b0;
    repeat (3) tick;
    total++;
    if ({busy, done, mgmt_write, pll_rst} !== 4'd0) begin
      bad++;
      $display("FAIL midrst_idle: got busy=%b done=%b wr=%b prst=%b want 0", busy, done, mgmt_write, pll_rst);
    end
  endtask

  task automatic test_ignored;
    int n;
    request(18'h00111, 18'h00222, 18'h00333, 32'haaaa5555);
    cfg_m = 18'h3ffff; cfg_n = 18'h3fffe; cfg_c0 = 18'h3fffd; cfg_k = 32'hffffffff; cfg_req = 1'b1;
    for (int i = 0; i < NW; i++) begin
      total++;
      if (mgmt_write !== 1'b1 || mgmt_address !== ea[i] || mgmt_writedata !== ed[i]) begin
        bad++;
        $display("FAIL ignored_write%0d: got wr=%b addr=%0d data=%h want wr=1 addr=%0d data=%h",
                 i, mgmt_write, mgmt_address, mgmt_writedata, ea[i], ed[i]);
      end
      tick;
      cfg_req = 1'b0;
    end
    cfg_req = 1'b1;
    tick;
    cfg_req = 1'b0;
    total++;
    if (mgmt_write !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ignored_wait: got wr=%b busy=%b want wr=0 busy=1", mgmt_write, busy);
    end
    locked = 1'b1;
    wait_done(20, n);
    total++;
    if (n !== 6 || error !== 1'b0) begin
      bad++;
      $display("FAIL ignored_done: got delay=%0d err=%b want delay=6 err=0", n, error);
    end
    locked = 1'b0;
    tick;
  endtask

  initial begin
    rst = 1'b1; cfg_req = 1'b0; cfg_m = '0; cfg_n = '0; cfg_c0 = '0; cfg_k = '0;
    locked = 1'b0; mgmt_waitrequest = 1'b0;
    test_reset;
    test_basic;
    test_stall;
    test_glitch;
    test_retry;
    test_fail;
    test_mid_reset;
    test_ignored;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
